// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz timing constants, derived totals and counter width for
// the VGA timing generator.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;

  localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef logic [CNT_W-1:0] cnt_t;

  // True when lo <= cnt < lo+len.
  function automatic logic in_window(cnt_t cnt, int lo, int len);
    return (int'(cnt) >= lo) && (int'(cnt) < lo + len);
  endfunction

endpackage

// File: rtl/pix_tick_div.sv
// Pixel-rate tick divider: pix_tick is high on the clk where the divider sits
// at its last count, so CLK_DIV=1 yields a constantly high tick.
module pix_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;

  always_comb begin
    pix_tick  = (div_cnt_q == DIV_LAST);
    div_cnt_d = pix_tick ? '0 : div_cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters plus sync, valid and frame_start
// flags, all registered together on each pixel tick.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             pix_tick,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             hsync,
  output logic             vsync,
  output logic             valid,
  output logic             frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_cfg
    $error("vga_timing_gen: totals must fit 10-bit counters and CLK_DIV must be >= 1");
  end

  cnt_t h_cnt_q, h_cnt_d;
  cnt_t v_cnt_q, v_cnt_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic valid_q, valid_d;
  logic frame_start_q, frame_start_d;

  pix_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk      (clk),
    .rst      (rst),
    .pix_tick (pix_tick)
  );

  // Flags are decoded from the next counter values so they land on the same
  // edge as the coordinates they describe.
  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    valid_d       = valid_q;
    frame_start_d = frame_start_q;
    if (pix_tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + cnt_t'(1);
      end else begin
        h_cnt_d = h_cnt_q + cnt_t'(1);
      end
      hsync_d = in_window(h_cnt_d, H_VISIBLE + H_FP, H_SYNC) ? SYNC_POL : !SYNC_POL;
      vsync_d = in_window(v_cnt_d, V_VISIBLE + V_FP, V_SYNC) ? SYNC_POL : !SYNC_POL;
      valid_d = (int'(h_cnt_d) < H_VISIBLE) && (int'(v_cnt_d) < V_VISIBLE);
      frame_start_d = (h_cnt_d == '0) && (v_cnt_d == '0);
    end
  end

  // Counters park at the last position so the first tick lands on (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q       <= H_LAST;
      v_cnt_q       <= V_LAST;
      hsync_q       <= !SYNC_POL;
      vsync_q       <= !SYNC_POL;
      valid_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      valid_q       <= valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign h_cnt       = h_cnt_q;
  assign v_cnt       = v_cnt_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign valid       = valid_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Upstream stage of the pixel-address path. Generates 640x480@60 Hz VGA timing from the 100 MHz system clock using an internal pixel-rate tick. Produces the raw h_cnt/v_cnt coordinates consumed by the address generator, plus hsync/vsync/valid for the VGA pins and colour gating. All outputs are registered and change only on pixel ticks.

Parameters:
CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); legal range 1..16
H_VISIBLE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
pix_tick  output  1  one-clk pulse every CLK_DIV clocks; all other outputs update on the clk edge where pix_tick is high
h_cnt  output  10  horizontal position, 0..H_TOTAL-1
v_cnt  output  10  vertical position, 0..V_TOTAL-1
hsync  output  1  horizontal sync, SYNC_POL when asserted
vsync  output  1  vertical sync, SYNC_POL when asserted
valid  output  1  1 when h_cnt<H_VISIBLE and v_cnt<V_VISIBLE
frame_start  output  1  high for one pixel period while (h_cnt,v_cnt)=(0,0)

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Derived: H_TOTAL=H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL=V_VISIBLE+V_FP+V_SYNC+V_BP (525).
- Tick divider: div_cnt counts 0..CLK_DIV-1 and wraps. pix_tick=1 on the clk where div_cnt==CLK_DIV-1. CLK_DIV=1 gives pix_tick constantly high.
- Reset values: div_cnt=0, pix_tick=0, h_cnt=H_TOTAL-1 (799), v_cnt=V_TOTAL-1 (524), hsync=vsync=!SYNC_POL, valid=0, frame_start=0.
  - The first pix_tick after reset wraps the counters to (0,0), so a frame always starts cleanly.
- On each pix_tick:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt advances.
  - v_cnt increments only on h wrap; at V_TOTAL-1 it wraps to 0.
- hsync, vsync, valid and frame_start are computed from the next counter values and registered in the same edge, so they are exactly aligned with h_cnt/v_cnt (zero relative latency).
- hsync asserted iff H_VISIBLE+H_FP <= h_cnt < H_VISIBLE+H_FP+H_SYNC (656..751).
- vsync asserted iff V_VISIBLE+V_FP <= v_cnt < V_VISIBLE+V_FP+V_SYNC (490..491), for whole lines.
- Between ticks all outputs hold. pix_tick is the only output that pulses at the clk rate.
- rst mid-frame: the next edge forces the reset values regardless of pix_tick. The divider restarts from 0, so the first post-reset tick arrives CLK_DIV clks after rst falls.
- Counter widths are 10 bits. Elaboration-time check: H_TOTAL<=1024, V_TOTAL<=1024, CLK_DIV>=1.

Decomposition:
- Package vga_timing_pkg holds the 640x480 timing constants (visible, porch and sync values), derived totals, and the counter width constant (10).
- Sub-module pix_tick_div (parameter CLK_DIV) contains the divider counter and the pix_tick output.
- The counter and sync logic stays in vga_timing_gen.

Test Plan:
- Reset: assert rst 3 clks, release. Outputs must hold reset values. First pix_tick at clk 4 (CLK_DIV=4) gives h_cnt=0, v_cnt=0, valid=1, frame_start=1.
- Tick spacing: run 40 clks. pix_tick pulses every 4th clk, and h_cnt changes only on those clks, increasing by exactly 1.
- Horizontal window: over one line, valid=1 for h 0..639. hsync=0 for h 656..751 (96 ticks) and 1 elsewhere. At h=799 the next tick gives h=0 and v+1.
- Frame wrap: run to (799,524). The next tick gives (0,0) with frame_start=1 for exactly one pixel period. vsync=0 for lines 490..491 only. Frame length is exactly 420000 ticks.
- Mid-frame reset: assert rst at (300,200). The next clk gives (799,524), valid=0, hsync=vsync=1. Resume and check the normal sequence from (0,0).
- CLK_DIV=1: pix_tick constantly high and counters advance every clk. Confirm the 800x525 cycle and sync widths unchanged in ticks.
